// File: rtl/frame_tx_packer.sv
// Frame transmitter: streams a 12-byte little-endian header and then 16-bit samples (LSB first) to a byte UART.
// A small FIFO decouples sample arrival from UART pacing; every send is followed by one holdoff cycle.
module frame_tx_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] release_id,
    input  logic [31:0] series_id,
    input  logic [31:0] length,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic [7:0]  tx_data,
    output logic        tx_send,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, HEADER, PAY_LSB, PAY_MSB, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      rel_q;
    logic [31:0]      ser_q;
    logic [31:0]      len_q;
    logic [CNT_W-1:0] len_cnt;
    logic [3:0]       byte_idx;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic             holdoff;
    logic [7:0]       data_q;
    logic [7:0]       word_hi;
    logic [7:0]       send_byte;
    logic             send;
    logic             pop;
    logic             push;
    logic             accept;

    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_full;
    logic             fifo_empty;

    assign len_cnt    = CNT_W'(len_q);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign accept     = (state == IDLE) && start;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign s_ready    = busy && !fifo_full && (in_cnt < len_cnt);
    assign push       = s_valid && s_ready;
    assign tx_send    = send;
    assign tx_data    = send_byte;

    // tx_data falls back to the last sent byte so it stays stable between sends
    always_comb begin
        state_next = state;
        send       = 1'b0;
        pop        = 1'b0;
        send_byte  = data_q;
        case (state)
            IDLE: begin
                if (start) state_next = HEADER;
            end
            HEADER: begin
                if (tx_ready && !holdoff) begin
                    send      = 1'b1;
                    send_byte = 8'({len_q, ser_q, rel_q} >> {byte_idx, 3'b000});
                    if (byte_idx == 4'd11) state_next = (len_q != '0) ? PAY_LSB : DONE;
                end
            end
            PAY_LSB: begin
                if (tx_ready && !holdoff && !fifo_empty) begin
                    send       = 1'b1;
                    pop        = 1'b1;
                    send_byte  = mem[rd_ptr][7:0];
                    state_next = PAY_MSB;
                end
            end
            PAY_MSB: begin
                if (tx_ready && !holdoff) begin
                    send       = 1'b1;
                    send_byte  = word_hi;
                    state_next = (out_cnt + CNT_W'(1) == len_cnt) ? DONE : PAY_LSB;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rel_q    <= '0;
            ser_q    <= '0;
            len_q    <= '0;
            byte_idx <= '0;
            in_cnt   <= '0;
            out_cnt  <= '0;
            holdoff  <= 1'b0;
            data_q   <= '0;
            word_hi  <= '0;
        end else begin
            state   <= state_next;
            holdoff <= send;
            if (send) data_q <= send_byte;
            if (accept) begin
                rel_q    <= release_id;
                ser_q    <= series_id;
                len_q    <= length;
                byte_idx <= '0;
                in_cnt   <= '0;
                out_cnt  <= '0;
            end else begin
                if (push) in_cnt <= in_cnt + CNT_W'(1);
                if (send && state == HEADER) byte_idx <= byte_idx + 4'd1;
                if (pop) word_hi <= mem[rd_ptr][15:8];
                if (send && state == PAY_MSB) out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (accept) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_frame_tx_packer.sv
// Scoreboard bench for frame_tx_packer: a byte-level frame model feeds a queue that a monitor drains on every tx_send.
// Covers the basic frame, zero length, UART backpressure, FIFO full/over-supply, start while busy and reset mid-frame.
module tb_frame_tx_packer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] release_id = '0;
    logic [31:0] series_id = '0;
    logic [31:0] length = '0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data = '0;
    logic        s_ready;
    logic [7:0]  tx_data;
    logic        tx_send;
    logic        tx_ready;
    logic        busy;
    logic        done;

    logic        main_ready = 1'b1;
    logic        bp_ready = 1'b1;
    bit          bp_en = 1'b0;
    int          bp_low = 0;

    int          compared = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] samp_q[$];
    int          samp_idx = 0;
    int          acc_cnt = 0;
    bit          extra_en = 1'b0;
    bit          gap_en = 1'b0;
    logic [15:0] extra_val = '0;
    int          cyc = 0;
    int          t0 = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          frame_sent = 0;
    int          last_send = -100;
    bit          strict_gap = 1'b0;
    bit          sready_seen = 1'b0;

    assign tx_ready = bp_en ? bp_ready : main_ready;

    frame_tx_packer #(.FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .release_id(release_id),
        .series_id(series_id),
        .length(length),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .tx_data(tx_data),
        .tx_send(tx_send),
        .tx_ready(tx_ready),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected byte on every send and checks pacing rules
    initial forever begin
        @(negedge clk);
        if (!reset_n) begin
            frame_sent = 0;
            last_send  = -100;
        end else begin
            if (tx_send) begin
                checkOutput("send_needs_ready", 32'(tx_ready), 32'd1);
                if (strict_gap && frame_sent > 0)
                    checkOutput("send_gap", 32'(cyc - last_send), 32'd2);
                else
                    checkOutput("send_holdoff", 32'(cyc - last_send >= 2), 32'd1);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no send", tx_data);
                end else begin
                    checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                last_send = cyc;
                frame_sent++;
            end
            if (s_ready) sready_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                checkOutput("done_after_last_byte", 32'(exp_q.size()), 32'd0);
                frame_sent = 0;
            end
        end
        cyc++;
    end

    // Sample driver: offers the frame's samples in order, then optionally an extra value forever
    initial forever begin
        @(negedge clk);
        if (reset_n && s_valid && s_ready) begin
            acc_cnt++;
            samp_idx++;
        end
        @(posedge clk);
        #2;
        if (samp_idx < samp_q.size()) begin
            s_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = samp_q[samp_idx];
        end else if (extra_en) begin
            s_valid = 1'b1;
            s_data  = extra_val;
        end else begin
            s_valid = 1'b0;
        end
    end

    // Random UART backpressure: low stretches of 0-5 cycles
    initial forever begin
        @(posedge clk);
        #3;
        if (bp_low > 0) begin
            bp_ready = 1'b0;
            bp_low--;
        end else begin
            bp_ready = 1'b1;
            if ($urandom_range(0, 2) == 0) bp_low = $urandom_range(0, 5);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Builds the expected byte stream from header words and samples, then pulses start
    task automatic applyStimulus(input logic [31:0] rel, input logic [31:0] ser, input int len);
        logic [31:0] hdr [3];
        hdr[0] = rel;
        hdr[1] = ser;
        hdr[2] = 32'(len);
        while (samp_q.size() < len) samp_q.push_back(16'($urandom));
        samp_idx    = 0;
        acc_cnt     = 0;
        sready_seen = 1'b0;
        for (int w = 0; w < 3; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(hdr[w] >> (8 * b)));
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(samp_q[i][7:0]);
            exp_q.push_back(samp_q[i][15:8]);
        end
        release_id = rel;
        series_id  = ser;
        length     = 32'(len);
        start      = 1'b1;
        t0         = cyc;
        waitCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int bound, input int exp_cycles);
        int n = 0;
        int base = done_cnt;
        while (done_cnt == base && n < bound) begin
            waitCycle();
            n++;
        end
        if (done_cnt == base) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL %s_timeout: got no done within %0d cycles, expected done", name, bound);
        end else begin
            if (exp_cycles > 0) checkOutput({name, "_cycles"}, 32'(done_cyc - t0), 32'(exp_cycles));
            checkOutput({name, "_busy_after"}, 32'(busy), 32'd0);
            checkOutput({name, "_done_single"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int len;
        int guard;
        int base;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_tx_send", 32'(tx_send), 32'd0);
        checkOutput("reset_tx_data", 32'(tx_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
        reset_n = 1'b1;
        waitCycle();

        // Basic frame at full UART rate
        main_ready = 1'b1;
        strict_gap = 1'b1;
        samp_q.delete();
        samp_q.push_back(16'h1234);
        samp_q.push_back(16'hBEEF);
        applyStimulus(32'h04030201, 32'h0A0B0C0D, 2);
        waitDone("basic", 200, 2 * (12 + 2 * 2));
        checkOutput("basic_samples_taken", 32'(acc_cnt), 32'd2);

        // Zero-length frame
        samp_q.delete();
        applyStimulus($urandom, $urandom, 0);
        waitDone("zero", 100, 2 * 12);
        checkOutput("zero_sready_never", 32'(sready_seen), 32'd0);

        // Backpressure with random sample gaps
        strict_gap = 1'b0;
        gap_en     = 1'b1;
        bp_en      = 1'b1;
        for (int f = 0; f < 4; f++) begin
            len = (f == 0) ? 3 : int'($urandom_range(0, 5));
            samp_q.delete();
            applyStimulus($urandom, $urandom, len);
            waitDone("backpressure", 2000, 0);
            checkOutput("bp_samples_taken", 32'(acc_cnt), 32'(len));
        end
        bp_en  = 1'b0;
        gap_en = 1'b0;

        // FIFO full with over-supply
        main_ready = 1'b0;
        strict_gap = 1'b1;
        samp_q.delete();
        for (int i = 0; i < 6; i++) samp_q.push_back(16'h0A00 + 16'(i));
        extra_val = 16'h0A06;
        extra_en  = 1'b1;
        applyStimulus($urandom, $urandom, 6);
        repeat (30) waitCycle();
        checkOutput("fifo_full_accepted", 32'(acc_cnt), 32'(DEPTH));
        checkOutput("fifo_full_s_ready", 32'(s_ready), 32'd0);
        checkOutput("fifo_full_no_send", 32'(frame_sent), 32'd0);
        main_ready = 1'b1;
        waitDone("fifo", 300, 0);
        repeat (4) waitCycle();
        checkOutput("oversupply_not_taken", 32'(acc_cnt), 32'd6);
        extra_en = 1'b0;

        // Start while busy is ignored
        samp_q.delete();
        applyStimulus(32'hA1A2A3A4, 32'hB1B2B3B4, 4);
        guard = 0;
        while (frame_sent < 15 && guard < 200) begin
            waitCycle();
            guard++;
        end
        release_id = 32'hDEADBEEF;
        series_id  = 32'hCAFEF00D;
        length     = 32'd9;
        start      = 1'b1;
        waitCycle();
        start = 1'b0;
        waitDone("busy_start", 300, 2 * (12 + 2 * 4));

        // New frame uses new ids; a start held only during DONE is ignored
        base = done_cnt;
        samp_q.delete();
        applyStimulus(32'h11223344, 32'h55667788, 1);
        repeat (27) waitCycle();
        release_id = 32'h99999999;
        start      = 1'b1;
        @(negedge clk);
        checkOutput("done_cycle_new_frame", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) waitCycle();
        checkOutput("start_in_done_busy", 32'(busy), 32'd0);
        checkOutput("start_in_done_done_count", 32'(done_cnt - base), 32'd1);

        // Reset during PAY_MSB, then a clean one-sample frame
        samp_q.delete();
        samp_q.push_back(16'h1111);
        samp_q.push_back(16'h2222);
        samp_q.push_back(16'h3333);
        applyStimulus($urandom, $urandom, 3);
        guard = 0;
        while (frame_sent < 13 && guard < 200) begin
            waitCycle();
            guard++;
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_tx_send", 32'(tx_send), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_done", 32'(done), 32'd0);
        checkOutput("midreset_s_ready", 32'(s_ready), 32'd0);
        exp_q.delete();
        samp_q.delete();
        samp_idx = 0;
        acc_cnt  = 0;
        waitCycle();
        waitCycle();
        reset_n = 1'b1;
        waitCycle();
        checkOutput("post_reset_idle", 32'(busy), 32'd0);
        samp_q.push_back(16'hC0DE);
        applyStimulus($urandom, $urandom, 1);
        waitDone("post_reset", 200, 2 * (12 + 2));
        checkOutput("post_reset_samples", 32'(acc_cnt), 32'd1);

        repeat (5) waitCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/frame_tx_packer.md
Name: frame_tx_packer

Overview:
- Transmit-side counterpart of the host-to-FPGA frame receiver: packs processed 16-bit results (SMA/EMA) into the same frame format and streams them to the UART byte transmitter.
- Frame = 12-byte header (release_id, series_id, length; each 32-bit little-endian) followed by `length` 16-bit samples, LSB first.
- Sits between the calculators and uartInterface send/data_in/tx_ready; a small FIFO decouples sample production from UART pacing.

Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of two, >= 2.
- CNT_W, 32, width of the sample counters; must cover `length`.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- release_id  in  32  header field, latched on accepted start
- series_id  in  32  header field, latched on accepted start
- length  in  32  number of 16-bit samples in the frame, latched on accepted start
- s_valid  in  1  sample valid
- s_data  in  16  sample value
- s_ready  out  1  sample accepted when s_valid && s_ready
- tx_data  out  8  byte to UART (uart data_in)
- tx_send  out  1  one-cycle send strobe to UART
- tx_ready  in  1  UART transmitter idle
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse when the last byte of a frame has been issued

Behaviour:
- Reset values: all outputs 0. State = IDLE. FIFO empty. Counters 0. Latched fields 0.
- Reset mid-frame: frame aborted immediately, FIFO flushed, no further bytes issued.
- States: IDLE, HEADER, PAY_LSB, PAY_MSB, DONE.
- IDLE:
  - On start=1: latch release_id/series_id/length, clear byte_idx, in_cnt and out_cnt, go to HEADER.
  - busy rises on the next cycle.
- Byte issue rule (all sending states):
  - tx_send=1 for exactly one cycle, with tx_data valid in that same cycle.
  - Allowed only when tx_ready=1 and holdoff=0.
  - holdoff is set for the single cycle following any tx_send; tx_ready is ignored during that cycle.
  - Sends are therefore never back-to-back.
  - tx_data holds its value until the next send.
- HEADER: issues byte_idx 0..11.
  - Order: release_id[7:0], [15:8], [23:16], [31:24]; then series_id in the same order; then length in the same order.
  - After byte 11: go to PAY_LSB if length != 0, else DONE.
- PAY_LSB:
  - Wait until FIFO is non-empty.
  - On send: pop the FIFO head into word_reg, send word_reg[7:0] (the head value in the same cycle), go to PAY_MSB.
- PAY_MSB:
  - On send: send word_reg[15:8] and increment out_cnt.
  - If out_cnt+1 == length go to DONE, else go to PAY_LSB.
- DONE: done=1 for one cycle, busy=0 on exit, return to IDLE.
- Sample input:
  - s_ready = busy && !fifo_full && (in_cnt < length).
  - Samples may be accepted during HEADER, before the payload starts.
  - Samples offered beyond `length` see s_ready=0 and are never consumed.
  - In IDLE, s_ready=0.
- FIFO:
  - Push and pop in the same cycle are legal; the count is unchanged.
  - Full-to-not-full and empty transitions are exact; there is no overflow or underflow under any stimulus.
- start while busy: ignored; latched fields unchanged.
- start in the DONE cycle: ignored; it is accepted only in IDLE, one cycle later.
- Total bytes per frame = 12 + 2*length. Minimum cycles per frame with tx_ready tied high = 2*(12 + 2*length), since sends occur every other cycle.
- Width rules: counters are CNT_W unsigned. length=0xFFFFFFFF is legal; no wrap occurs because the comparisons are exact.

Test Plan:
- Basic frame: start with release_id=0x04030201, series_id=0x0A0B0C0D, length=2; samples 0x1234, 0xBEEF; tx_ready=1 -> bytes 01 02 03 04 0D 0C 0B 0A 02 00 00 00 34 12 EF BE; 16 single-cycle tx_send pulses, each separated by exactly 1 idle cycle; done pulses once; busy=0 afterwards.
- Zero length: length=0 -> exactly 12 header bytes, done pulses, s_ready never 1.
- UART backpressure: tx_ready toggled with a random 0-5 cycle low time, length=3 -> byte sequence identical to the tx_ready=1 run; no tx_send while tx_ready=0 or in a holdoff cycle.
- FIFO full and over-supply:
  - Setup: FIFO_DEPTH=4, tx_ready held 0, length=6, s_valid held 1 with an incrementing value.
  - Expected: exactly 4 samples accepted, then s_ready=0 until a pop.
  - After release: all 6 samples are sent in order; the 7th offered sample is never accepted.
- Start while busy: pulse start with different ids mid-payload -> the current frame is unchanged; a new start after done produces a frame with the new ids.
- Reset mid-frame: assert reset_n=0 during PAY_MSB -> tx_send, busy, done and s_ready are 0 immediately; after release, a fresh length=1 frame transmits cleanly with no stale FIFO data.
